// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: registered operand forwarding, stall generation and multi-cycle slot tracking for a 5-stage pipeline
// Ports: clk/rst (async active-high); id_* decode-side instruction info; flush squashes ID;
// stall (combinational) holds PC/IF-ID and bubbles EX; fwd_a/fwd_b registered EX operand selects;
// md_busy/md_done/md_rd report the multi-cycle unit.
module fwd_hazard_unit #(
    parameter int REG_AW   = 4,
    parameter int MD_LAT   = 4,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wen,
    input  logic [1:0]        id_kind,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              md_busy,
    output logic              md_done,
    output logic [REG_AW-1:0] md_rd
);
    localparam int CW = $clog2(MD_LAT + 1);
    localparam logic [1:0] K_LOAD = 2'b01;
    localparam logic [1:0] K_MD   = 2'b10;
    logic              r_ex_v, r_ex_ld, r_mem_v;
    logic [REG_AW-1:0] r_ex_rd, r_mem_rd, r_md_rd;
    logic [CW-1:0]     r_cnt;
    logic [1:0]        r_fwd_a, r_fwd_b;
    logic              w_busy, w_lu, w_raw, w_waw, w_str, w_issue, w_md_issue;
    function automatic logic hit(input logic [REG_AW-1:0] src, input logic use_bit,
                                 input logic [REG_AW-1:0] rd, input logic v);
        return v && use_bit && src == rd && !(ZERO_REG && src == '0);
    endfunction
    // Newest producer wins: the multi-cycle result landing next cycle, then EX, then MEM.
    // WB needs no path since the regfile writes before it reads.
    function automatic logic [1:0] fsel(input logic [REG_AW-1:0] src, input logic use_bit);
        return (r_cnt == CW'(2) && hit(src, use_bit, r_md_rd, 1'b1)) ? 2'b11 :
               hit(src, use_bit, r_ex_rd, r_ex_v && !r_ex_ld)         ? 2'b01 :
               hit(src, use_bit, r_mem_rd, r_mem_v)                    ? 2'b10 : 2'b00;
    endfunction
    always_comb begin
        w_busy     = r_cnt != '0;
        w_lu       = r_ex_ld && (hit(id_rs1, id_use1, r_ex_rd, r_ex_v) ||
                                 hit(id_rs2, id_use2, r_ex_rd, r_ex_v));
        w_raw      = r_cnt > CW'(2) && (hit(id_rs1, id_use1, r_md_rd, 1'b1) ||
                                        hit(id_rs2, id_use2, r_md_rd, 1'b1));
        w_waw      = w_busy && id_wen && id_rd == r_md_rd && !(ZERO_REG && id_rd == '0);
        w_str      = r_cnt > CW'(1) && id_kind == K_MD;
        stall      = id_valid && !flush && (w_lu || w_raw || w_waw || w_str);
        w_issue    = id_valid && !flush && !stall;
        w_md_issue = w_issue && id_kind == K_MD;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_v   <= 1'b0;
            r_ex_ld  <= 1'b0;
            r_ex_rd  <= '0;
            r_mem_v  <= 1'b0;
            r_mem_rd <= '0;
            r_md_rd  <= '0;
            r_cnt    <= '0;
            r_fwd_a  <= 2'b00;
            r_fwd_b  <= 2'b00;
        end else begin
            r_ex_v   <= w_issue && id_wen && id_kind != K_MD;
            r_ex_ld  <= w_issue && id_kind == K_LOAD;
            r_ex_rd  <= id_rd;
            r_mem_v  <= r_ex_v;
            r_mem_rd <= r_ex_rd;
            r_md_rd  <= w_md_issue ? id_rd : r_md_rd;
            // Reload takes priority so a MULDIV issued in the done cycle follows with no gap.
            r_cnt    <= w_md_issue ? CW'(MD_LAT) : w_busy ? r_cnt - CW'(1) : r_cnt;
            r_fwd_a  <= w_issue ? fsel(id_rs1, id_use1) : 2'b00;
            r_fwd_b  <= w_issue ? fsel(id_rs2, id_use2) : 2'b00;
        end
    end
    assign fwd_a   = r_fwd_a;
    assign fwd_b   = r_fwd_b;
    assign md_busy = w_busy;
    assign md_done = r_cnt == CW'(1);
    assign md_rd   = r_md_rd;
endmodule
